// File: rtl/ram_bank_param.sv
`default_nettype none
// ============================================================================
// Module   : ram_bank_param
// Purpose  : Parametrised single-port register-file RAM with registered,
//            valid-qualified reads and a one-word-per-cycle clear sequencer.
// Revision : 1.0  initial release
// ============================================================================
module ram_bank_param #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              rw,
    input  logic [ADDR_W-1:0] address,
    input  logic [WIDTH-1:0]  in,
    output logic [WIDTH-1:0]  out,
    output logic              out_valid,
    input  logic              clr,
    output logic              busy
);
    localparam logic [ADDR_W:0]   c_depth = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [WIDTH-1:0]  r_out;
    logic              r_out_valid;

    logic              w_in_range;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [WIDTH-1:0]  w_wr_data;
    logic              w_rd_en;

    // Non-power-of-two depths leave a hole at the top of the address space.
    assign w_in_range = ({1'b0, address} < c_depth);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wr_en     = 1'b0;
        w_wr_addr   = address;
        w_wr_data   = in;
        w_rd_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clr) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end else if (en) begin
                    if (rw) begin
                        w_wr_en = w_in_range;
                    end else begin
                        w_rd_en = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                // The clear reuses the write port; user requests are ignored.
                w_wr_en   = 1'b1;
                w_wr_addr = r_cnt;
                w_wr_data = '0;
                if (r_cnt == c_last) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + ADDR_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_rd_en;
            if (w_rd_en) begin
                r_out <= w_in_range ? r_mem[address] : '0;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign busy      = (r_state == ST_CLEAR);

endmodule
`default_nettype wire
